// File: rtl/demux_rr_scheduler.sv
// Round-robin beat scheduler for a 1-to-4 demux; DEMUX_BURST_EN holds each target for BURST_LEN accepts.
// Latency: 1 clk from accept to out_valid, sustaining 1 beat/clk.
// Backpressure: in_ready follows out_ready of the held channel; stalls while no channel is enabled.
module demux_rr_scheduler #(
  parameter int DW        = 2,
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [3:0]         ch_en,
  output logic [1:0]         sel,
  output logic [DW-1:0]      out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  input  logic               clr_cnt,
  output logic [4*CNT_W-1:0] cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic             accept, deliver, any_en;
  logic [1:0]       ptr, target;
  logic [CNT_W-1:0] cnt_q [4];

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst
    $error("BURST_LEN must be in 1..15");
  end

  assign any_en  = |ch_en;
  assign accept  = in_valid & in_ready;
  assign deliver = |(out_valid & out_ready);

  // First enabled channel at or after ptr; the lowest offset wins.
  always_comb begin
    target = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (ch_en[ptr + 2'(k)]) target = ptr + 2'(k);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 4'b0000;
    case (state)
      EMPTY: begin
        in_ready = any_en & ~rst;
        if (in_valid && in_ready) state_nxt = FULL;
      end
      FULL: begin
        out_valid = 4'b0001 << sel;
        in_ready  = out_ready[sel] & any_en & ~rst;
        if (out_ready[sel] && !(in_valid && in_ready)) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      sel      <= 2'd0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel      <= target;
        out_data <= in_data;
      end
    end
  end

`ifdef DEMUX_BURST_EN
  logic [3:0] burst_cnt, burst_base;

  // A run only continues while the channel ptr points at stays enabled.
  assign burst_base = ch_en[ptr] ? burst_cnt : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 2'd0;
      burst_cnt <= 4'd0;
    end else if (accept) begin
      if ((burst_base + 4'd1) >= 4'(BURST_LEN)) begin
        ptr       <= target + 2'd1;
        burst_cnt <= 4'd0;
      end else begin
        ptr       <= target;
        burst_cnt <= burst_base + 4'd1;
      end
    end else if (!ch_en[ptr]) begin
      burst_cnt <= 4'd0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= 2'd0;
    else if (accept) ptr <= target + 2'd1;
  end
`endif

  // Clear wins over a same-cycle delivery, so that beat goes uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clr_cnt) cnt_q[i] <= '0;
        else if (deliver && sel == 2'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed and randomized bench for demux_rr_scheduler against a transaction-level reference model.
module tb_demux_rr_scheduler;
  localparam int DW    = 2;
  localparam int CNT_W = 8;
`ifdef DEMUX_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [3:0]       ch_en;
  logic [1:0]       sel;
  logic [DW-1:0]    out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic             clr_cnt;
  logic [4*CNT_W-1:0] cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: held beat, pointer, run length and counts.
  bit m_full;
  int m_sel, m_data, m_ptr, m_run;
  int m_cnt [4];

  always #5 clk = ~clk;

  demux_rr_scheduler #(.DW(DW), .CNT_W(CNT_W), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ch_en(ch_en), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .cnt(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_full = 0; m_sel = 0; m_data = 0; m_ptr = 0; m_run = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  function automatic bit m_in_ready();
    if (rst || ch_en == 4'b0) return 1'b0;
    if (!m_full) return 1'b1;
    return out_ready[m_sel];
  endfunction

  function automatic int m_target();
    for (int k = 0; k < 4; k++) if (ch_en[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return m_ptr;
  endfunction

  function automatic int dut_cnt(input int ch);
    return int'(cnt[ch*CNT_W +: CNT_W]);
  endfunction

  // Compare all outputs mid-cycle, then advance one clock and update the model.
  task automatic cyc();
    bit acc, del;
    int t;
    #1;
    if (rst) m_reset();
    chk("in_ready", in_ready, m_in_ready());
    chk("out_valid", out_valid, m_full ? (32'd1 << m_sel) : 32'd0);
    chk("sel", sel, m_sel);
    chk("out_data", out_data, m_data);
    for (int i = 0; i < 4; i++) chk("cnt", dut_cnt(i), m_cnt[i]);
    acc = in_valid && m_in_ready();
    del = m_full && out_ready[m_sel];
    @(posedge clk);
    if (!rst) begin
      if (clr_cnt) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (del && m_cnt[m_sel] < (1 << CNT_W) - 1) begin
        m_cnt[m_sel]++;
      end
      if (!ch_en[m_ptr]) m_run = 0;
      if (acc) begin
        t = m_target();
        m_sel = t; m_data = int'(in_data); m_full = 1;
        m_run++;
        if (m_run >= BL) begin m_ptr = (t + 1) % 4; m_run = 0; end
        else m_ptr = t;
      end else if (del) begin
        m_full = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    int d;
    rst = 1'b1; in_valid = 0; in_data = '0; ch_en = 4'hF; out_ready = 4'hF; clr_cnt = 0;
    m_reset();
    @(negedge clk);
    do_reset();
    #1 chk("in_ready_after_reset", in_ready, 1'b1);
    cyc();

    // Rotation over all four channels.
    d = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = DW'(d); d = (d + 1) % 4; cyc();
    end
    in_valid = 0; cyc(); cyc();
`ifndef DEMUX_BURST_EN
    chk("rot_cnt_w", dut_cnt(0), 2); chk("rot_cnt_x", dut_cnt(1), 1);
    chk("rot_cnt_y", dut_cnt(2), 1); chk("rot_cnt_z", dut_cnt(3), 1);
`endif

    // Disabled channels are skipped.
    do_reset();
    clr_cnt = 1; cyc(); clr_cnt = 0;
    ch_en = 4'b1010;
    for (int i = 0; i < 4; i++) begin in_valid = 1; in_data = DW'(i); cyc(); end
    in_valid = 0; cyc(); cyc();
`ifndef DEMUX_BURST_EN
    chk("skip_cnt_x", dut_cnt(1), 2); chk("skip_cnt_z", dut_cnt(3), 2);
    chk("skip_cnt_w", dut_cnt(0), 0); chk("skip_cnt_y", dut_cnt(2), 0);
`endif

    // Backpressure on X.
    ch_en = 4'b0010; out_ready = 4'b1101;
    in_valid = 1; in_data = 2'd2; cyc();
    in_data = 2'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_out_valid", out_valid, 4'b0010);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_data", out_data, 2'd2);
      cyc();
    end
    out_ready = 4'hF; #1 chk("bp_release_in_ready", in_ready, 1'b1);
    cyc(); in_valid = 0; cyc();

    // No channel enabled: input stalls.
    ch_en = 4'b0; in_valid = 1;
    for (int i = 0; i < 6; i++) begin #1 chk("no_en_in_ready", in_ready, 1'b0); cyc(); end
    in_valid = 0;

    // Mask dropped while held on Y.
    ch_en = 4'b0100; out_ready = 4'b0; in_valid = 1; in_data = 2'd1; cyc();
    in_valid = 0; ch_en = 4'b0; cyc(); cyc();
    #1 chk("drop_out_valid", out_valid, 4'b0100);
    d = dut_cnt(2);
    out_ready = 4'hF; cyc();
    chk("drop_cnt_y", dut_cnt(2), d + 1);

    // Clear coinciding with a delivery.
    ch_en = 4'hF; out_ready = 4'b0; in_valid = 1; in_data = 2'd0; cyc();
    in_valid = 0; out_ready = 4'hF; clr_cnt = 1; cyc(); clr_cnt = 0;
    for (int i = 0; i < 4; i++) chk("clr_vs_deliver", dut_cnt(i), 0);

    // Reset while a beat is held.
    out_ready = 4'b0; in_valid = 1; in_data = 2'd3; cyc(); cyc();
    in_valid = 0; rst = 1; #1;
    chk("rst_out_valid", out_valid, 4'b0); chk("rst_sel", sel, 2'd0);
    chk("rst_in_ready", in_ready, 1'b0); chk("rst_cnt", cnt, 32'd0);
    cyc(); rst = 0; out_ready = 4'hF;
    #1 chk("rst_release_in_ready", in_ready, 1'b1);
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      ch_en     = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15));
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom_range(0, 3));
      clr_cnt   = ($urandom_range(0, 39) == 0);
      cyc();
    end
    in_valid = 0; clr_cnt = 0; out_ready = 4'hF; ch_en = 4'hF; cyc(); cyc();

    // Counter saturation on W.
    clr_cnt = 1; cyc(); clr_cnt = 0;
    ch_en = 4'b0001; in_valid = 1;
    for (int i = 0; i < 300; i++) begin in_data = DW'(i); cyc(); end
    in_valid = 0; cyc(); cyc();
    chk("sat_cnt_w", dut_cnt(0), 255);

    // Eight beats from a fresh pointer with every channel enabled.
    do_reset();
    ch_en = 4'hF;
    for (int i = 0; i < 8; i++) begin in_valid = 1; in_data = DW'(i); cyc(); end
    in_valid = 0; cyc(); cyc();
`ifdef DEMUX_BURST_EN
    chk("burst_cnt_w", dut_cnt(0), 4); chk("burst_cnt_x", dut_cnt(1), 4);
    chk("burst_cnt_y", dut_cnt(2), 0);
`else
    chk("eight_cnt_w", dut_cnt(0), 2); chk("eight_cnt_x", dut_cnt(1), 2);
    chk("eight_cnt_z", dut_cnt(3), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
